// File: rtl/memory_arbiter_pkg.sv
// Shared types and constants for the two-port memory arbiter.
package memory_arbiter_pkg;

  localparam int unsigned ADDR_W_DEF = 6;
  localparam int unsigned DATA_W_DEF = 32;
  localparam int unsigned GRANT_W    = 2;

  localparam logic [GRANT_W-1:0] GRANT_NONE = 2'b00;
  localparam logic [GRANT_W-1:0] GRANT_I    = 2'b01;
  localparam logic [GRANT_W-1:0] GRANT_D    = 2'b10;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/memory_arbiter_arb_pick.sv
// Combinational two-request picker for the memory arbiter.
// MEMORY_ARBITER_RR_EN selects round-robin on collisions; otherwise the data
// cache always wins.
module arb_pick
  import memory_arbiter_pkg::*;
(
  input  logic               i_req_i,
  input  logic               i_req_d,
  input  logic               i_last_i,
  output logic [GRANT_W-1:0] o_winner_c
);

`ifdef MEMORY_ARBITER_RR_EN
  // On a collision the port that was not served last wins
  always_comb begin
    o_winner_c = GRANT_NONE;
    if (i_req_i && i_req_d) begin
      o_winner_c = i_last_i ? GRANT_D : GRANT_I;
    end else if (i_req_d) begin
      o_winner_c = GRANT_D;
    end else if (i_req_i) begin
      o_winner_c = GRANT_I;
    end
  end
`else
  logic w_unused_last;
  assign w_unused_last = i_last_i;

  // Fixed priority: data cache first
  always_comb begin
    o_winner_c = GRANT_NONE;
    if (i_req_d) begin
      o_winner_c = GRANT_D;
    end else if (i_req_i) begin
      o_winner_c = GRANT_I;
    end
  end
`endif

endmodule

// File: rtl/memory_arbiter.sv
// Arbiter sharing one block memory between the instruction and data caches.
// Optional round-robin collision policy: define MEMORY_ARBITER_RR_EN.
module memory_arbiter
  import memory_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              I_READ,
  input  logic [ADDR_W-1:0] I_ADDRESS,
  output logic [DATA_W-1:0] I_READDATA,
  output logic              I_BUSYWAIT,
  input  logic              D_READ,
  input  logic              D_WRITE,
  input  logic [ADDR_W-1:0] D_ADDRESS,
  input  logic [DATA_W-1:0] D_WRITEDATA,
  output logic [DATA_W-1:0] D_READDATA,
  output logic              D_BUSYWAIT,
  output logic              MEM_READ,
  output logic              MEM_WRITE,
  output logic [ADDR_W-1:0] MEM_ADDRESS,
  output logic [DATA_W-1:0] MEM_WRITEDATA,
  input  logic [DATA_W-1:0] MEM_READDATA,
  input  logic              MEM_BUSYWAIT,
  output logic [1:0]        GRANT
);

  state_e             r_state;
  state_e             w_state_next;
  logic               w_load;
  logic               w_finish;
  logic               w_req_i;
  logic               w_req_d;
  logic               w_last_i;
  logic [GRANT_W-1:0] w_winner;
  logic [GRANT_W-1:0] r_grant;
  logic               r_mem_read;
  logic               r_mem_write;
  logic [ADDR_W-1:0]  r_mem_addr;
  logic [DATA_W-1:0]  r_mem_wdata;
  logic [DATA_W-1:0]  r_i_rdata;
  logic [DATA_W-1:0]  r_d_rdata;
  logic               w_done_i;
  logic               w_done_d;

  assign w_req_i = I_READ;
  assign w_req_d = D_READ | D_WRITE;

  arb_pick u_arb_pick (
    .i_req_i    (w_req_i),
    .i_req_d    (w_req_d),
    .i_last_i   (w_last_i),
    .o_winner_c (w_winner)
  );

  // State register
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next state plus load/finish strobes for the datapath
  always_comb begin
    w_state_next = r_state;
    w_load       = 1'b0;
    w_finish     = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_winner != GRANT_NONE) begin
          w_load       = 1'b1;
          w_state_next = ISSUE;
        end
      end
      ISSUE: begin
        if (MEM_BUSYWAIT) begin
          w_state_next = WAIT;
        end
      end
      WAIT: begin
        if (!MEM_BUSYWAIT) begin
          w_finish     = 1'b1;
          w_state_next = DONE;
        end
      end
      DONE:    w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // Owner, command, address and write-data registers
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_grant     <= GRANT_NONE;
      r_mem_read  <= 1'b0;
      r_mem_write <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
    end else begin
      if (w_load) begin
        r_grant <= w_winner;
        if (w_winner == GRANT_D) begin
          r_mem_addr  <= D_ADDRESS;
          r_mem_wdata <= D_WRITEDATA;
          r_mem_write <= D_WRITE;
          r_mem_read  <= ~D_WRITE;
        end else begin
          r_mem_addr  <= I_ADDRESS;
          r_mem_write <= 1'b0;
          r_mem_read  <= 1'b1;
        end
      end
      if (w_finish) begin
        r_mem_read  <= 1'b0;
        r_mem_write <= 1'b0;
      end
      if (r_state == DONE) begin
        r_grant <= GRANT_NONE;
      end
    end
  end

  // Per-port read data, updated only when a read for that port completes
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_i_rdata <= '0;
      r_d_rdata <= '0;
    end else if (w_finish && r_mem_read) begin
      if (r_grant == GRANT_I) begin
        r_i_rdata <= MEM_READDATA;
      end else begin
        r_d_rdata <= MEM_READDATA;
      end
    end
  end

`ifdef MEMORY_ARBITER_RR_EN
  logic r_last_i;

  // Remember which port finished last for round-robin
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_last_i <= 1'b1;
    end else if (w_finish) begin
      r_last_i <= (r_grant == GRANT_I);
    end
  end

  assign w_last_i = r_last_i;
`else
  assign w_last_i = 1'b1;
`endif

  // Requesters stall until their own DONE cycle; forced low in reset
  assign w_done_i   = (r_state == DONE) && (r_grant == GRANT_I);
  assign w_done_d   = (r_state == DONE) && (r_grant == GRANT_D);
  assign I_BUSYWAIT = RESET & w_req_i & ~w_done_i;
  assign D_BUSYWAIT = RESET & w_req_d & ~w_done_d;

  assign I_READDATA    = r_i_rdata;
  assign D_READDATA    = r_d_rdata;
  assign MEM_READ      = r_mem_read;
  assign MEM_WRITE     = r_mem_write;
  assign MEM_ADDRESS   = r_mem_addr;
  assign MEM_WRITEDATA = r_mem_wdata;
  assign GRANT         = r_grant;

endmodule

// File: tb/tb_memory_arbiter.sv
// Randomized self-checking bench for memory_arbiter against a transaction model.
module tb_memory_arbiter;
  import memory_arbiter_pkg::*;

  localparam int unsigned AW = 6;
  localparam int unsigned DW = 32;

  logic          CLK = 1'b0;
  logic          RESET = 1'b0;
  logic          I_READ = 1'b0;
  logic [AW-1:0] I_ADDRESS = '0;
  logic [DW-1:0] I_READDATA;
  logic          I_BUSYWAIT;
  logic          D_READ = 1'b0;
  logic          D_WRITE = 1'b0;
  logic [AW-1:0] D_ADDRESS = '0;
  logic [DW-1:0] D_WRITEDATA = '0;
  logic [DW-1:0] D_READDATA;
  logic          D_BUSYWAIT;
  logic          MEM_READ;
  logic          MEM_WRITE;
  logic [AW-1:0] MEM_ADDRESS;
  logic [DW-1:0] MEM_WRITEDATA;
  logic [DW-1:0] MEM_READDATA;
  logic          MEM_BUSYWAIT;
  logic [1:0]    GRANT;

  memory_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .CLK(CLK), .RESET(RESET),
    .I_READ(I_READ), .I_ADDRESS(I_ADDRESS), .I_READDATA(I_READDATA), .I_BUSYWAIT(I_BUSYWAIT),
    .D_READ(D_READ), .D_WRITE(D_WRITE), .D_ADDRESS(D_ADDRESS), .D_WRITEDATA(D_WRITEDATA),
    .D_READDATA(D_READDATA), .D_BUSYWAIT(D_BUSYWAIT),
    .MEM_READ(MEM_READ), .MEM_WRITE(MEM_WRITE), .MEM_ADDRESS(MEM_ADDRESS),
    .MEM_WRITEDATA(MEM_WRITEDATA), .MEM_READDATA(MEM_READDATA), .MEM_BUSYWAIT(MEM_BUSYWAIT),
    .GRANT(GRANT)
  );

  always #5 CLK = ~CLK;

  int            n_tests = 0;
  int            n_fail  = 0;

  // Environment memory (responder) and the bench's own expectation of its contents
  logic [DW-1:0] mem    [64];
  logic [DW-1:0] shadow [64];
  int unsigned   lat     = 1;
  int unsigned   mem_cnt = 0;

  // Expected architectural state
  logic [DW-1:0] exp_rd_i;
  logic [DW-1:0] exp_rd_d;
  logic          exp_last_i;

  // Memory responder: busy as soon as a command appears, for lat cycles
  assign MEM_BUSYWAIT = (MEM_READ | MEM_WRITE) && (mem_cnt < lat);
  assign MEM_READDATA = mem[MEM_ADDRESS];

  always @(posedge CLK) begin
    if (MEM_READ | MEM_WRITE) begin
      if (MEM_WRITE && !MEM_BUSYWAIT) mem[MEM_ADDRESS] <= MEM_WRITEDATA;
      mem_cnt <= mem_cnt + 1;
    end else begin
      mem_cnt <= 0;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Who the arbitration rule says goes first when both ports ask together
  function automatic logic [1:0] collision_winner();
`ifdef MEMORY_ARBITER_RR_EN
    return exp_last_i ? GRANT_D : GRANT_I;
`else
    return GRANT_D;
`endif
  endfunction

  // Follow one transfer from its ISSUE cycle through DONE and the following IDLE.
  // Called at the negedge where the grant must already be visible.
  task automatic serve(input logic [1:0] owner, input logic [AW-1:0] addr, input logic wr,
                       input logic [DW-1:0] wdata, input bit raise_i, input logic [AW-1:0] i_addr);
    int n;
    bit done;
    logic own_bw;
    chk("grant", 32'(GRANT), 32'(owner));
    chk("cmd", 32'({MEM_READ, MEM_WRITE}), wr ? 32'd1 : 32'd2);
    chk("mem_addr", 32'(MEM_ADDRESS), 32'(addr));
    if (wr) chk("mem_wdata", MEM_WRITEDATA, wdata);
    n = 0;
    done = 1'b0;
    while (!done && n < int'(lat) + 8) begin
      @(negedge CLK);
      n++;
      own_bw = (owner == GRANT_I) ? I_BUSYWAIT : D_BUSYWAIT;
      if (!own_bw) begin
        done = 1'b1;
      end else begin
        if (owner == GRANT_D && I_READ) chk("i_held", 32'(I_BUSYWAIT), 32'd1);
        if (owner == GRANT_I && (D_READ | D_WRITE)) chk("d_held", 32'(D_BUSYWAIT), 32'd1);
        if (raise_i && n == 1) begin
          I_READ = 1'b1;
          I_ADDRESS = i_addr;
        end
      end
    end
    chk("done_cycle", 32'(n), 32'(lat + 1));
    chk("done_cmd", 32'({MEM_READ, MEM_WRITE}), 32'd0);
    chk("done_grant", 32'(GRANT), 32'(owner));
    if (wr) shadow[addr] = wdata;
    else if (owner == GRANT_I) exp_rd_i = shadow[addr];
    else exp_rd_d = shadow[addr];
    chk("i_rdata", I_READDATA, exp_rd_i);
    chk("d_rdata", D_READDATA, exp_rd_d);
    exp_last_i = (owner == GRANT_I);
    if (owner == GRANT_I) I_READ = 1'b0;
    else begin
      D_READ = 1'b0;
      D_WRITE = 1'b0;
    end
    @(negedge CLK);
    chk("idle_grant", 32'(GRANT), 32'(GRANT_NONE));
  endtask

  // kind 0: lone I; 1: lone D; 2: I and D together; 3: D then I raised mid-transfer
  task automatic do_txn(input int kind, input int unsigned lat_v, input logic [AW-1:0] ai,
                        input logic [AW-1:0] ad, input logic [1:0] dwr, input logic [DW-1:0] wd);
    logic [1:0] first;
    logic [1:0] second;
    lat = lat_v;
    if (kind != 0) begin
      D_READ = dwr[0];
      D_WRITE = dwr[1];
      D_ADDRESS = ad;
      D_WRITEDATA = wd;
    end
    if (kind == 0 || kind == 2) begin
      I_READ = 1'b1;
      I_ADDRESS = ai;
    end
    @(negedge CLK);
    case (kind)
      0: serve(GRANT_I, ai, 1'b0, wd, 1'b0, ai);
      1: serve(GRANT_D, ad, dwr[1], wd, 1'b0, ai);
      2: begin
        first = collision_winner();
        second = (first == GRANT_I) ? GRANT_D : GRANT_I;
        serve(first, (first == GRANT_I) ? ai : ad, (first == GRANT_D) && dwr[1], wd, 1'b0, ai);
        @(negedge CLK);
        serve(second, (second == GRANT_I) ? ai : ad, (second == GRANT_D) && dwr[1], wd, 1'b0, ai);
      end
      default: begin
        serve(GRANT_D, ad, dwr[1], wd, 1'b1, ai);
        @(negedge CLK);
        serve(GRANT_I, ai, 1'b0, wd, 1'b0, ai);
      end
    endcase
  endtask

  // Reset pulse while a data read sits in WAIT; the held request is re-run after release
  task automatic reset_mid();
    logic [AW-1:0] a;
    a = AW'($urandom);
    lat = 6;
    D_READ = 1'b1;
    D_ADDRESS = a;
    @(negedge CLK);
    chk("rst_pre_grant", 32'(GRANT), 32'(GRANT_D));
    @(negedge CLK);
    @(negedge CLK);
    #2 RESET = 1'b0;
    #1;
    chk("rst_cmd", 32'({MEM_READ, MEM_WRITE}), 32'd0);
    chk("rst_grant", 32'(GRANT), 32'(GRANT_NONE));
    chk("rst_addr", 32'(MEM_ADDRESS), 32'd0);
    chk("rst_wdata", MEM_WRITEDATA, 32'd0);
    chk("rst_i_rdata", I_READDATA, 32'd0);
    chk("rst_d_rdata", D_READDATA, 32'd0);
    chk("rst_d_bw", 32'(D_BUSYWAIT), 32'd0);
    exp_rd_i = '0;
    exp_rd_d = '0;
    exp_last_i = 1'b1;
    @(negedge CLK);
    RESET = 1'b1;
    lat = 2;
    @(negedge CLK);
    serve(GRANT_D, a, 1'b0, '0, 1'b0, '0);
  endtask

  initial begin
    logic [1:0] dwr;
    for (int i = 0; i < 64; i++) begin
      mem[i] = $urandom;
      shadow[i] = mem[i];
    end
    mem[5] = 32'hA1B2C3D4;
    shadow[5] = 32'hA1B2C3D4;
    exp_rd_i = '0;
    exp_rd_d = '0;
    exp_last_i = 1'b1;

    // Reset state, with requests asserted to show busywaits are forced low
    I_READ = 1'b1;
    D_WRITE = 1'b1;
    #12;
    chk("reset_grant", 32'(GRANT), 32'(GRANT_NONE));
    chk("reset_cmd", 32'({MEM_READ, MEM_WRITE}), 32'd0);
    chk("reset_addr", 32'(MEM_ADDRESS), 32'd0);
    chk("reset_rdata", I_READDATA | D_READDATA, 32'd0);
    chk("reset_bw", 32'({I_BUSYWAIT, D_BUSYWAIT}), 32'd0);
    I_READ = 1'b0;
    D_WRITE = 1'b0;
    @(negedge CLK);
    RESET = 1'b1;
    @(negedge CLK);

    do_txn(0, 5, 6'h05, 6'h00, 2'b00, 32'h0);
    do_txn(1, 3, 6'h00, 6'h3F, 2'b10, 32'hDEADBEEF);
    for (int r = 0; r < 3; r++) do_txn(2, 2, AW'($urandom), AW'($urandom), 2'b01, 32'h0);
    do_txn(1, 2, 6'h00, 6'h11, 2'b11, 32'h5A5A_0011);
    do_txn(3, 4, 6'h11, 6'h22, 2'b01, 32'h0);
    reset_mid();
    do_txn(2, 1, AW'($urandom), AW'($urandom), 2'b01, 32'h0);

    for (int r = 0; r < 40; r++) begin
      case ($urandom_range(0, 2))
        0: dwr = 2'b01;
        1: dwr = 2'b10;
        default: dwr = 2'b11;
      endcase
      do_txn(int'($urandom_range(0, 3)), $urandom_range(1, 6), AW'($urandom), AW'($urandom),
             dwr, $urandom);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got time %0t expected below 500000", $time);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/memory_arbiter.md
# memory_arbiter

Two-port arbiter sharing the single main data memory between the instruction cache (read-only refills) and the data cache (refills and write-backs). It sits between both cache controllers and the memory and accepts one block request at a time. It drives the memory's READ/WRITE/BUSYWAIT handshake and stalls the losing cache through its BUSYWAIT until the winner's transfer completes.

## Interface

Parameters:
- ADDR_W, 6, block address width.
- DATA_W, 32, block data width.

Ports:
- CLK  in  1  system clock; all state changes on rising edge.
- RESET  in  1  asynchronous, active-low reset.
- I_READ  in  1  instruction-cache block read request.
- I_ADDRESS  in  ADDR_W  instruction-cache block address.
- I_READDATA  out  DATA_W  block returned to instruction cache.
- I_BUSYWAIT  out  1  stall to instruction cache.
- D_READ  in  1  data-cache block read request.
- D_WRITE  in  1  data-cache block write-back request.
- D_ADDRESS  in  ADDR_W  data-cache block address.
- D_WRITEDATA  in  DATA_W  write-back block.
- D_READDATA  out  DATA_W  block returned to data cache.
- D_BUSYWAIT  out  1  stall to data cache.
- MEM_READ  out  1  memory read command.
- MEM_WRITE  out  1  memory write command.
- MEM_ADDRESS  out  ADDR_W  memory block address.
- MEM_WRITEDATA  out  DATA_W  memory write block.
- MEM_READDATA  in  DATA_W  memory read block.
- MEM_BUSYWAIT  in  1  memory busy.
- GRANT  out  2  current owner: 00 none, 01 instruction, 10 data.

## Operation

- FSM states: IDLE, ISSUE, WAIT, DONE.
- IDLE: sample requests at the edge. If none, stay. If any, pick an owner, latch its address, write data and command into registers, then go to ISSUE.
- ISSUE: MEM_READ/MEM_WRITE and address/data are driven from the registers. If MEM_BUSYWAIT=1, go to WAIT; otherwise stay.
- WAIT: on an edge with MEM_BUSYWAIT=0, capture MEM_READDATA into the owner's READDATA register (reads only), clear MEM_READ/MEM_WRITE, and go to DONE.
- DONE: one cycle, then go to IDLE. GRANT returns to 00 on entry to IDLE.
- Data-cache command: D_WRITE=1 → write, else D_READ=1 → read. D_READ and D_WRITE both high: write wins.
- I_BUSYWAIT = I_READ and not (state=DONE and owner=instruction). D_BUSYWAIT = (D_READ or D_WRITE) and not (state=DONE and owner=data). Both are combinational.
- A requester must drop or change its request at the edge ending DONE. The value sampled in the following IDLE cycle is treated as a new request.
- I_READDATA/D_READDATA hold their last value until the next read completes for that port.
- Reset, asynchronous, at any time including mid-transfer:
  - state IDLE, GRANT 00, MEM_READ/MEM_WRITE 0, MEM_ADDRESS 0, MEM_WRITEDATA 0, both READDATA 0, last-served = instruction.
  - While RESET=0, I_BUSYWAIT and D_BUSYWAIT are forced to 0.
  - An aborted transfer is not replayed.

## Timing

- A request is first seen at edge k (IDLE). The memory command is asserted from edge k+1. The memory raises MEM_BUSYWAIT in the same cycle.
- If MEM_BUSYWAIT falls before edge m, DONE runs from m to m+1. Requester BUSYWAIT is low and READDATA is valid during that cycle.
- Minimum occupancy: 4 cycles plus memory latency.
- No back-to-back grants: at least one IDLE cycle separates transfers.
- A request arriving mid-transfer is held (BUSYWAIT=1) until the next IDLE.

## Configuration

- MEMORY_ARBITER_RR_EN defined:
  - Round-robin on simultaneous requests: the port not served last wins.
  - last-served updates when entering DONE.
- MEMORY_ARBITER_RR_EN undefined:
  - Fixed priority, data cache always wins.
  - The last-served register is not built.

## Structure

- Package memory_arbiter_pkg holds:
  - state enum (IDLE, ISSUE, WAIT, DONE);
  - GRANT encodings (GRANT_NONE, GRANT_I, GRANT_D);
  - default ADDR_W/DATA_W constants.
- Sub-module arb_pick: combinational 2-request picker. Inputs are both requests and last-served; output is the winner. It contains the MEMORY_ARBITER_RR_EN logic.
- The top level holds the FSM, command/address/data registers, read-data registers and busywait logic.

## Test plan

- Lone I_READ, addr 0x05, memory busy 5 cycles returning 0xA1B2C3D4:
  - MEM_READ=1 and MEM_ADDRESS=0x05 from the next edge.
  - I_READDATA=0xA1B2C3D4 and I_BUSYWAIT=0 exactly in DONE.
  - GRANT 01 then 00.
- D_WRITE addr 0x3F, data 0xDEADBEEF:
  - MEM_WRITE=1, MEM_WRITEDATA=0xDEADBEEF, MEM_READ=0.
  - D_READDATA unchanged.
- I_READ and D_READ raised on the same edge:
  - Fixed priority: data served first, then instruction after one IDLE cycle.
  - RR_EN after reset: data first (last-served = instruction).
  - RR_EN repeated: ports alternate.
- D_READ and D_WRITE both high: a write is issued.
- I_READ raised during a data transfer: I_BUSYWAIT=1 throughout, and the instruction transfer starts after the data DONE.
- RESET pulsed low in WAIT:
  - MEM_READ/MEM_WRITE drop asynchronously, all outputs 0, state IDLE.
  - After release, a held request is re-arbitrated normally.
